vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Memory-side responder for the shared 32k x 16 video RAM.
- Serves three initiators:
  - sprite scanline renderer (read-only, 64-word window at the top of RAM)
  - tile renderer (read-only)
  - CPU (read/write)
- Drives the single RAM port and returns read data.
- Posts one CPU write while video owns the bus, and asserts CPU hold only when a CPU request cannot be accepted.
- Sits between the renderers/CPU and RAM_sync; the platform top instantiates it.

Parameters:
- ADDR_W, 15, RAM word-address width
- DATA_W, 16, RAM data width
- SPRITE_BASE, 9'h1FC, upper address bits prepended to the 6-bit sprite address (window 0x7F00-0x7F3F)
- STALL_W, 8, width of the stall counters

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high reset
- sprite_busy  in  1  sprite renderer owns the bus this cycle
- sprite_addr  in  6  sprite word offset
- tile_busy  in  1  tile renderer owns the bus this cycle
- tile_addr  in  ADDR_W  tile word address
- video_rdata  out  DATA_W  RAM read data for the renderers, equal to ram_dout (combinational)
- cpu_req  in  1  CPU requests an access
- cpu_write  in  1  1 = write, 0 = read (qualified by cpu_req)
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_ack  out  1  request accepted this cycle (combinational)
- cpu_hold  out  1  equals cpu_req & ~cpu_ack
- cpu_rdata  out  DATA_W  registered read data, held until the next read completes
- cpu_rvalid  out  1  one-cycle pulse, one cycle after read acceptance
- ram_addr  out  ADDR_W  RAM address (combinational)
- ram_din  out  DATA_W  RAM write data
- ram_we  out  1  RAM write enable
- ram_dout  in  DATA_W  RAM_sync read data (valid the cycle after the address)
- stall_max  out  STALL_W  longest consecutive cpu_hold run since reset, saturating

Behaviour:
- Reset values: wbuf_valid=0, wbuf_addr=0, wbuf_data=0, cpu_rvalid=0, cpu_rdata=0, stall_cnt=0, stall_max=0.
- RAM port owner, fixed priority per cycle:
  - sprite_busy: ram_addr={SPRITE_BASE,sprite_addr}, ram_we=0
  - else tile_busy: ram_addr=tile_addr, ram_we=0
  - else wbuf_valid: drain the buffer (ram_addr=wbuf_addr, ram_din=wbuf_data, ram_we=1), then wbuf_valid<=0
  - else cpu_req: the CPU access drives the port directly
  - else ram_we=0, ram_addr=cpu_addr
- video_free = ~sprite_busy & ~tile_busy.
- Write acceptance: cpu_req & cpu_write & ~wbuf_valid → cpu_ack=1.
  - If video_free: written to RAM this cycle.
  - Else: captured into wbuf (wbuf_valid<=1).
  - A write with wbuf_valid=1 is held, even in the cycle the buffer drains; it is accepted no earlier than the next cycle.
- Read acceptance: cpu_req & ~cpu_write & video_free & ~wbuf_valid → cpu_ack=1, ram_addr=cpu_addr.
  - Next cycle: cpu_rvalid=1 and cpu_rdata<=ram_dout.
  - Back-to-back reads give one result per cycle.
- Ordering: a read never bypasses a posted write, so read-after-write to the same address returns the new data.
- Video masters are never stalled. video_rdata is valid the cycle after the respective *_busy/address.
- Stall counters:
  - stall_cnt increments (saturating at all-ones) each cycle cpu_hold=1; it clears on any cycle with cpu_hold=0.
  - stall_max<=max(stall_max, stall_cnt+1 saturated) on each hold cycle.
- Reset mid-operation: a pending posted write is discarded (not written) and a pending rvalid is dropped.
- cpu_req=0: cpu_ack=0, no CPU RAM activity; address/data inputs are ignored.

Test Plan:
- Idle bus, CPU writes 0x1234 to 0x0100 → same cycle ram_we=1, ram_addr=0x0100; cpu_ack=1, cpu_hold=0.
- tile_busy=1 with tile_addr=0x6000, CPU writes 0xBEEF to 0x0005 → cpu_ack=1, wbuf filled, RAM sees the tile address. First cycle tile_busy=0 → ram_we=1 to 0x0005 with 0xBEEF.
- With wbuf full (tile busy 3 cycles), a second CPU write → cpu_hold=1 until the cycle after the drain; stall_max ≥ 3.
- Posted write 0xAAAA to 0x0010, then a read of 0x0010 once video is free → write drains first; the read is acked the following cycle; cpu_rvalid=1 next cycle with cpu_rdata=0xAAAA.
- sprite_busy & tile_busy both 1, sprite_addr=0x05 → ram_addr=0x7F05; a CPU read is held; video_rdata equals RAM[0x7F05] one cycle later.
- Posted write pending, assert reset one cycle → wbuf_valid=0, no RAM write afterwards, cpu_rvalid=0, stall_max=0.

Source files
------------

// File: rtl/vram_arbiter_if.sv
// Bus bundle between the video-RAM arbiter and its initiators / RAM_sync.
// The slave modport is the arbiter's view; master is the initiator/RAM side.
interface vram_arbiter_if #(
    parameter int ADDR_W  = 15,
    parameter int DATA_W  = 16,
    parameter int STALL_W = 8
);
    logic              sprite_busy;
    logic [5:0]        sprite_addr;
    logic              tile_busy;
    logic [ADDR_W-1:0] tile_addr;
    logic [DATA_W-1:0] video_rdata;

    logic              cpu_req;
    logic              cpu_write;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic              cpu_hold;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_we;
    logic [DATA_W-1:0] ram_dout;

    logic [STALL_W-1:0] stall_max;

    modport slave (
        input  sprite_busy, sprite_addr, tile_busy, tile_addr,
        input  cpu_req, cpu_write, cpu_addr, cpu_wdata, ram_dout,
        output video_rdata, cpu_ack, cpu_hold, cpu_rdata, cpu_rvalid,
        output ram_addr, ram_din, ram_we, stall_max
    );

    modport master (
        output sprite_busy, sprite_addr, tile_busy, tile_addr,
        output cpu_req, cpu_write, cpu_addr, cpu_wdata, ram_dout,
        input  video_rdata, cpu_ack, cpu_hold, cpu_rdata, cpu_rvalid,
        input  ram_addr, ram_din, ram_we, stall_max
    );
endinterface

// File: rtl/vram_arbiter.sv
// Single-port arbiter for the shared 32k x 16 video RAM: sprite > tile > posted
// CPU write > CPU access, with a one-entry write buffer and CPU stall statistics.
module vram_arbiter #(
    parameter int                  ADDR_W      = 15,
    parameter int                  DATA_W      = 16,
    parameter logic [ADDR_W-7:0]   SPRITE_BASE = 9'h1FC,
    parameter int                  STALL_W     = 8
) (
    input  logic          clk,
    input  logic          reset,
    vram_arbiter_if.slave bus
);

    logic              video_free;
    logic              drain;
    logic              wr_accept;
    logic              rd_accept;
    logic              hold;

    logic              wbuf_valid;
    logic [ADDR_W-1:0] wbuf_addr;
    logic [DATA_W-1:0] wbuf_data;

    logic              rvalid_q;
    logic [DATA_W-1:0] rdata_q;

    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_inc;
    logic [STALL_W-1:0] stall_max_q;

    // Any buffered write blocks new CPU traffic, so reads can never overtake it.
    // Draining is suppressed in a reset cycle so a discarded write never lands.
    assign video_free = ~bus.sprite_busy & ~bus.tile_busy;
    assign drain      = video_free & wbuf_valid & ~reset;
    assign wr_accept  = bus.cpu_req & bus.cpu_write & ~wbuf_valid;
    assign rd_accept  = bus.cpu_req & ~bus.cpu_write & video_free & ~wbuf_valid;
    assign hold       = bus.cpu_req & ~(wr_accept | rd_accept);
    assign stall_inc  = (stall_cnt == {STALL_W{1'b1}}) ? stall_cnt : stall_cnt + 1'b1;

    assign bus.cpu_ack     = wr_accept | rd_accept;
    assign bus.cpu_hold    = hold;
    assign bus.video_rdata = bus.ram_dout;
    assign bus.cpu_rvalid  = rvalid_q;
    assign bus.stall_max   = stall_max_q;
    // RAM_sync returns data one cycle late, so the result bypasses the hold register
    // during the rvalid cycle and is then held until the next read completes.
    assign bus.cpu_rdata   = rvalid_q ? bus.ram_dout : rdata_q;

    always_comb begin
        bus.ram_addr = bus.cpu_addr;
        bus.ram_din  = bus.cpu_wdata;
        bus.ram_we   = 1'b0;
        if (bus.sprite_busy) begin
            bus.ram_addr = {SPRITE_BASE, bus.sprite_addr};
        end else if (bus.tile_busy) begin
            bus.ram_addr = bus.tile_addr;
        end else if (drain) begin
            bus.ram_addr = wbuf_addr;
            bus.ram_din  = wbuf_data;
            bus.ram_we   = 1'b1;
        end else if (bus.cpu_req) begin
            bus.ram_we   = wr_accept;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wbuf_valid <= 1'b0;
            wbuf_addr  <= '0;
            wbuf_data  <= '0;
        end else if (wr_accept && !video_free) begin
            wbuf_valid <= 1'b1;
            wbuf_addr  <= bus.cpu_addr;
            wbuf_data  <= bus.cpu_wdata;
        end else if (drain) begin
            wbuf_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= rd_accept;
            if (rvalid_q) begin
                rdata_q <= bus.ram_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt   <= '0;
            stall_max_q <= '0;
        end else if (hold) begin
            stall_cnt <= stall_inc;
            if (stall_inc > stall_max_q) begin
                stall_max_q <= stall_inc;
            end
        end else begin
            stall_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: a RAM_sync model plus write/read scoreboards
// checked by a negedge monitor, and per-cycle checks of the combinational port.
module tb_vram_arbiter;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t         wexp[$];
    logic [15:0] rexp[$];

    logic [15:0] mem [0:32767] = '{default: 16'h0000};

    vram_arbiter_if #(.ADDR_W(15), .DATA_W(16), .STALL_W(8)) bus ();

    vram_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous RAM: read-before-write, data valid the cycle after the address
    always @(posedge clk) begin
        if (bus.ram_we === 1'b1) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic sb, input logic [5:0] sa,
                                 input logic tb_busy, input logic [14:0] ta,
                                 input logic req, input logic wr,
                                 input logic [14:0] addr, input logic [15:0] wd);
        reset           = rst;
        bus.sprite_busy = sb;
        bus.sprite_addr = sa;
        bus.tile_busy   = tb_busy;
        bus.tile_addr   = ta;
        bus.cpu_req     = req;
        bus.cpu_write   = wr;
        bus.cpu_addr    = addr;
        bus.cpu_wdata   = wd;
    endtask

    task automatic pushWrite(input logic [14:0] addr, input logic [15:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        wexp.push_back(w);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every RAM write and every read completion is matched against the queues
    always @(negedge clk) begin : monitor
        wr_t w;
        if (bus.ram_we === 1'b1) begin
            if (wexp.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_ram_write: got addr %h data %h, expected no write",
                         bus.ram_addr, bus.ram_din);
            end else begin
                w = wexp.pop_front();
                checkOutput("ram_write_addr", 32'(bus.ram_addr), 32'(w.addr));
                checkOutput("ram_write_data", 32'(bus.ram_din), 32'(w.data));
            end
        end
        if (bus.cpu_rvalid === 1'b1) begin
            if (rexp.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_rvalid: got rdata %h, expected no rvalid",
                         bus.cpu_rdata);
            end else begin
                checkOutput("cpu_rdata", 32'(bus.cpu_rdata), 32'(rexp.pop_front()));
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;

        applyStimulus(1, 0, 6'h00, 0, 15'h0000, 0, 0, 15'h0000, 16'h0000);
        repeat (2) @(posedge clk);
        #1;

        // Reset state on an idle bus
        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 0, 0, 15'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("reset_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        checkOutput("reset_rdata", 32'(bus.cpu_rdata), 32'h0);
        checkOutput("reset_stall_max", 32'(bus.stall_max), 32'd0);
        checkOutput("idle_ram_we", 32'(bus.ram_we), 32'd0);
        checkOutput("idle_ack", 32'(bus.cpu_ack), 32'd0);
        checkOutput("idle_hold", 32'(bus.cpu_hold), 32'd0);
        nextCycle();

        // Seed the sprite window through the CPU
        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 1, 1, 15'h7F05, 16'h5A5A);
        pushWrite(15'h7F05, 16'h5A5A);
        @(negedge clk);
        checkOutput("seed_ack", 32'(bus.cpu_ack), 32'd1);
        nextCycle();

        // Direct write on an idle bus
        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 1, 1, 15'h0100, 16'h1234);
        pushWrite(15'h0100, 16'h1234);
        @(negedge clk);
        checkOutput("direct_we", 32'(bus.ram_we), 32'd1);
        checkOutput("direct_addr", 32'(bus.ram_addr), 32'h0100);
        checkOutput("direct_ack", 32'(bus.cpu_ack), 32'd1);
        checkOutput("direct_hold", 32'(bus.cpu_hold), 32'd0);
        nextCycle();

        // Posted write while the tile renderer owns the bus
        applyStimulus(0, 0, 6'h00, 1, 15'h6000, 1, 1, 15'h0005, 16'hBEEF);
        pushWrite(15'h0005, 16'hBEEF);
        @(negedge clk);
        checkOutput("posted_ack", 32'(bus.cpu_ack), 32'd1);
        checkOutput("posted_ram_addr", 32'(bus.ram_addr), 32'h6000);
        checkOutput("posted_ram_we", 32'(bus.ram_we), 32'd0);
        nextCycle();

        // Second write held behind the full buffer for three tile cycles
        pushWrite(15'h0006, 16'h4321);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 6'h00, 1, 15'h6000, 1, 1, 15'h0006, 16'h4321);
            @(negedge clk);
            checkOutput("full_hold", 32'(bus.cpu_hold), 32'd1);
            checkOutput("full_ack", 32'(bus.cpu_ack), 32'd0);
            checkOutput("full_ram_addr", 32'(bus.ram_addr), 32'h6000);
            nextCycle();
        end

        // Drain cycle: buffer goes out, the waiting write is still held
        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 1, 1, 15'h0006, 16'h4321);
        @(negedge clk);
        checkOutput("drain_hold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("drain_we", 32'(bus.ram_we), 32'd1);
        checkOutput("drain_addr", 32'(bus.ram_addr), 32'h0005);
        checkOutput("drain_din", 32'(bus.ram_din), 32'hBEEF);
        nextCycle();

        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 1, 1, 15'h0006, 16'h4321);
        @(negedge clk);
        checkOutput("after_drain_ack", 32'(bus.cpu_ack), 32'd1);
        checkOutput("after_drain_hold", 32'(bus.cpu_hold), 32'd0);
        checkOutput("after_drain_addr", 32'(bus.ram_addr), 32'h0006);
        checkOutput("stall_max_4", 32'(bus.stall_max), 32'd4);
        nextCycle();

        // Posted write during sprite fetch, then read-after-write to the same word
        applyStimulus(0, 1, 6'h00, 0, 15'h0000, 1, 1, 15'h0010, 16'hAAAA);
        pushWrite(15'h0010, 16'hAAAA);
        @(negedge clk);
        checkOutput("sprite_post_ack", 32'(bus.cpu_ack), 32'd1);
        checkOutput("sprite_base_addr", 32'(bus.ram_addr), 32'h7F00);
        checkOutput("sprite_post_we", 32'(bus.ram_we), 32'd0);
        nextCycle();

        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 1, 0, 15'h0010, 16'h0000);
        rexp.push_back(16'hAAAA);
        @(negedge clk);
        checkOutput("raw_hold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("raw_drain_we", 32'(bus.ram_we), 32'd1);
        checkOutput("raw_drain_addr", 32'(bus.ram_addr), 32'h0010);
        nextCycle();

        @(negedge clk);
        checkOutput("raw_read_ack", 32'(bus.cpu_ack), 32'd1);
        checkOutput("raw_read_we", 32'(bus.ram_we), 32'd0);
        checkOutput("raw_read_addr", 32'(bus.ram_addr), 32'h0010);
        nextCycle();

        // Back-to-back reads, one result per cycle
        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 1, 0, 15'h0100, 16'h0000);
        rexp.push_back(16'h1234);
        @(negedge clk);
        checkOutput("b2b_ack0", 32'(bus.cpu_ack), 32'd1);
        checkOutput("b2b_rvalid0", 32'(bus.cpu_rvalid), 32'd1);
        nextCycle();

        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 1, 0, 15'h0005, 16'h0000);
        rexp.push_back(16'hBEEF);
        @(negedge clk);
        checkOutput("b2b_ack1", 32'(bus.cpu_ack), 32'd1);
        checkOutput("b2b_rvalid1", 32'(bus.cpu_rvalid), 32'd1);
        nextCycle();

        // Both renderers busy: sprite wins, CPU read held
        applyStimulus(0, 1, 6'h05, 1, 15'h6000, 1, 0, 15'h0006, 16'h0000);
        @(negedge clk);
        checkOutput("prio_ram_addr", 32'(bus.ram_addr), 32'h7F05);
        checkOutput("prio_hold", 32'(bus.cpu_hold), 32'd1);
        checkOutput("prio_ack", 32'(bus.cpu_ack), 32'd0);
        checkOutput("prio_we", 32'(bus.ram_we), 32'd0);
        nextCycle();

        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 0, 0, 15'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("video_rdata", 32'(bus.video_rdata), 32'h5A5A);
        checkOutput("rdata_held", 32'(bus.cpu_rdata), 32'hBEEF);
        checkOutput("idle_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        checkOutput("stall_max_kept", 32'(bus.stall_max), 32'd4);
        nextCycle();

        // Reset with a posted write pending: the write must never reach RAM
        applyStimulus(0, 0, 6'h00, 1, 15'h6000, 1, 1, 15'h0020, 16'h7777);
        @(negedge clk);
        checkOutput("pre_reset_post_ack", 32'(bus.cpu_ack), 32'd1);
        nextCycle();

        applyStimulus(1, 0, 6'h00, 0, 15'h0000, 0, 0, 15'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("reset_cycle_we", 32'(bus.ram_we), 32'd0);
        nextCycle();

        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 0, 0, 15'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("post_reset_we", 32'(bus.ram_we), 32'd0);
        checkOutput("post_reset_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        checkOutput("post_reset_rdata", 32'(bus.cpu_rdata), 32'h0);
        checkOutput("post_reset_stall_max", 32'(bus.stall_max), 32'd0);
        nextCycle();

        // Read accepted in a reset cycle: its rvalid is dropped
        applyStimulus(1, 0, 6'h00, 0, 15'h0000, 1, 0, 15'h0100, 16'h0000);
        nextCycle();
        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 0, 0, 15'h0000, 16'h0000);
        @(negedge clk);
        checkOutput("dropped_rvalid", 32'(bus.cpu_rvalid), 32'd0);
        nextCycle();

        // The discarded write left the old contents in place
        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 1, 0, 15'h0020, 16'h0000);
        rexp.push_back(16'h0000);
        @(negedge clk);
        checkOutput("final_read_ack", 32'(bus.cpu_ack), 32'd1);
        nextCycle();

        applyStimulus(0, 0, 6'h00, 0, 15'h0000, 0, 0, 15'h0000, 16'h0000);
        repeat (3) nextCycle();
        checkOutput("writes_outstanding", 32'(wexp.size()), 32'd0);
        checkOutput("reads_outstanding", 32'(rexp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
